// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pkg : shared FSM states, owner encoding and constants              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_D = 2'd1,
      ST_WAIT_I = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam logic        WE_RE_WRITE     = 1'b1;
   localparam logic        WE_RE_READ      = 1'b0;
   localparam int unsigned DEFAULT_TIMEOUT = 16;
   localparam int unsigned CNT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/arb_timeout_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_timeout_counter : counts WAIT cycles, flags the TIMEOUT-th one         |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module arb_timeout_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] count_inc;

   // count_q holds completed WAIT cycles, so count_inc numbers the current one
   always_comb begin
      count_inc = count_q + CNT_W'(1);
      count_d   = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = enable_i && (count_inc == TIMEOUT_C);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter : fixed-priority (data > fetch) share of one memory port  |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_request,
   input  logic        instr_we_re,
   input  logic [3:0]  instr_mask,
   input  logic [31:0] instr_address,
   input  logic        data_request,
   input  logic        data_we_re,
   input  logic [3:0]  data_mask,
   input  logic [31:0] data_address,
   input  logic [31:0] data_wdata,
   output logic        instr_valid,
   output logic        data_valid,
   output logic [31:0] rdata,
   output logic        rsp_error,
   output logic        mem_request,
   output logic        mem_we_re,
   output logic [3:0]  mem_mask,
   output logic [31:0] mem_address,
   output logic [31:0] mem_wdata,
   input  logic        mem_valid,
   input  logic [31:0] mem_rdata,
   output logic        bus_error
);

   arb_state_e  state_q, state_d;
   owner_e      owner_q, owner_d;
   logic        mem_request_q, mem_request_d;
   logic        mem_we_re_q, mem_we_re_d;
   logic [3:0]  mem_mask_q, mem_mask_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rsp_error_q, rsp_error_d;
   logic        bus_error_q, bus_error_d;
   logic        in_wait;
   logic        expired;

   assign in_wait = (state_q == ST_WAIT_D) || (state_q == ST_WAIT_I);

   arb_timeout_counter #(
      .TIMEOUT   (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (!in_wait),
      .enable_i  (in_wait),
      .expired_o (expired)
   );

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      mem_request_d = mem_request_q;
      mem_we_re_d   = mem_we_re_q;
      mem_mask_d    = mem_mask_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      rdata_d       = rdata_q;
      rsp_error_d   = rsp_error_q;
      bus_error_d   = bus_error_q;

      case (state_q)
         ST_IDLE: begin
            // Data wins ties: it belongs to the older instruction in the pipe
            if (data_request) begin
               state_d       = ST_WAIT_D;
               owner_d       = OWN_D;
               mem_request_d = 1'b1;
               mem_we_re_d   = data_we_re;
               mem_mask_d    = data_mask;
               mem_address_d = data_address;
               mem_wdata_d   = data_wdata;
            end else if (instr_request) begin
               state_d       = ST_WAIT_I;
               owner_d       = OWN_I;
               mem_request_d = 1'b1;
               mem_we_re_d   = instr_we_re;
               mem_mask_d    = instr_mask;
               mem_address_d = instr_address;
               mem_wdata_d   = '0;
            end
         end
         ST_WAIT_D, ST_WAIT_I: begin
            // mem_valid is checked first so a same-cycle expiry is not an error
            if (mem_valid) begin
               state_d       = ST_RESP;
               mem_request_d = 1'b0;
               rdata_d       = mem_rdata;
               rsp_error_d   = 1'b0;
            end else if (expired) begin
               state_d       = ST_RESP;
               mem_request_d = 1'b0;
               rdata_d       = '0;
               rsp_error_d   = 1'b1;
               bus_error_d   = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         owner_q       <= OWN_I;
         mem_request_q <= 1'b0;
         mem_we_re_q   <= WE_RE_READ;
         mem_mask_q    <= '0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         rdata_q       <= '0;
         rsp_error_q   <= 1'b0;
         bus_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         mem_request_q <= mem_request_d;
         mem_we_re_q   <= mem_we_re_d;
         mem_mask_q    <= mem_mask_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         rdata_q       <= rdata_d;
         rsp_error_q   <= rsp_error_d;
         bus_error_q   <= bus_error_d;
      end
   end

   assign instr_valid = (state_q == ST_RESP) && (owner_q == OWN_I);
   assign data_valid  = (state_q == ST_RESP) && (owner_q == OWN_D);
   assign rdata       = rdata_q;
   assign rsp_error   = rsp_error_q;
   assign mem_request = mem_request_q;
   assign mem_we_re   = mem_we_re_q;
   assign mem_mask    = mem_mask_q;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign bus_error   = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench, TIMEOUT = 4            |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic        instr_request;
   logic        instr_we_re;
   logic [3:0]  instr_mask;
   logic [31:0] instr_address;
   logic        data_request;
   logic        data_we_re;
   logic [3:0]  data_mask;
   logic [31:0] data_address;
   logic [31:0] data_wdata;
   logic        instr_valid;
   logic        data_valid;
   logic [31:0] rdata;
   logic        rsp_error;
   logic        mem_request;
   logic        mem_we_re;
   logic [3:0]  mem_mask;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic        bus_error;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_data;
   int t_instr;

   mem_port_arbiter #(
      .TIMEOUT       (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_request (instr_request),
      .instr_we_re   (instr_we_re),
      .instr_mask    (instr_mask),
      .instr_address (instr_address),
      .data_request  (data_request),
      .data_we_re    (data_we_re),
      .data_mask     (data_mask),
      .data_address  (data_address),
      .data_wdata    (data_wdata),
      .instr_valid   (instr_valid),
      .data_valid    (data_valid),
      .rdata         (rdata),
      .rsp_error     (rsp_error),
      .mem_request   (mem_request),
      .mem_we_re     (mem_we_re),
      .mem_mask      (mem_mask),
      .mem_address   (mem_address),
      .mem_wdata     (mem_wdata),
      .mem_valid     (mem_valid),
      .mem_rdata     (mem_rdata),
      .bus_error     (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      instr_request = 1'b0; instr_we_re = WE_RE_READ; instr_mask = 4'h0; instr_address = '0;
      data_request  = 1'b0; data_we_re  = WE_RE_READ; data_mask  = 4'h0; data_address  = '0;
      data_wdata    = '0;   mem_valid   = 1'b0;       mem_rdata  = '0;
      tick(); tick();

      // Reset state
      check_eq("rst_mem_request", mem_request, 0);
      check_eq("rst_instr_valid", instr_valid, 0);
      check_eq("rst_data_valid",  data_valid,  0);
      check_eq("rst_rdata",       rdata,       0);
      check_eq("rst_rsp_error",   rsp_error,   0);
      check_eq("rst_bus_error",   bus_error,   0);
      check_eq("rst_mem_address", mem_address, 0);
      rst = 1'b0;
      tick();

      // Single fetch, memory answers one WAIT cycle late (k = 1)
      instr_request = 1'b1; instr_address = 32'h100; instr_mask = 4'hF;
      tick();
      check_eq("f1_mem_request", mem_request, 1);
      check_eq("f1_mem_address", mem_address, 32'h100);
      check_eq("f1_mem_we_re",   mem_we_re,   0);
      check_eq("f1_mem_mask",    mem_mask,    4'hF);
      check_eq("f1_mem_wdata",   mem_wdata,   0);
      tick();
      check_eq("f1_no_early_valid", instr_valid, 0);
      mem_valid = 1'b1; mem_rdata = 32'h00500093;
      tick();
      mem_valid = 1'b0; mem_rdata = '0;
      check_eq("f1_instr_valid", instr_valid, 1);
      check_eq("f1_data_valid",  data_valid,  0);
      check_eq("f1_rdata",       rdata,       32'h00500093);
      check_eq("f1_rsp_error",   rsp_error,   0);
      check_eq("f1_req_dropped", mem_request, 0);
      instr_request = 1'b0;
      tick();
      check_eq("f1_single_pulse", instr_valid, 0);

      // Simultaneous store and fetch: store goes first
      data_request = 1'b1; data_we_re = WE_RE_WRITE; data_mask = 4'hF;
      data_address = 32'h2000; data_wdata = 32'hDEADBEEF;
      instr_request = 1'b1; instr_address = 32'h104;
      tick();
      check_eq("s2_mem_address", mem_address, 32'h2000);
      check_eq("s2_mem_we_re",   mem_we_re,   1);
      check_eq("s2_mem_wdata",   mem_wdata,   32'hDEADBEEF);
      check_eq("s2_mem_mask",    mem_mask,    4'hF);
      mem_valid = 1'b1; mem_rdata = 32'h11111111;
      tick();
      mem_valid = 1'b0;
      check_eq("s2_data_valid",  data_valid,  1);
      check_eq("s2_instr_quiet", instr_valid, 0);
      t_data = cyc;
      data_request = 1'b0; data_we_re = WE_RE_READ;
      tick();
      check_eq("s2_idle_gap", mem_request, 0);
      tick();
      check_eq("s2_fetch_req",   mem_request, 1);
      check_eq("s2_fetch_addr",  mem_address, 32'h104);
      check_eq("s2_fetch_wdata", mem_wdata,   0);
      check_eq("s2_fetch_we_re", mem_we_re,   0);
      mem_valid = 1'b1; mem_rdata = 32'h00A00113;
      tick();
      mem_valid = 1'b0;
      check_eq("s2_instr_valid", instr_valid, 1);
      check_eq("s2_instr_rdata", rdata,       32'h00A00113);
      t_instr = cyc;
      check_eq("s2_spacing", t_instr - t_data, 3);
      instr_request = 1'b0;
      tick();

      // Timeout: mem_valid never comes, TIMEOUT = 4
      data_request = 1'b1; data_address = 32'h3000; data_mask = 4'h3;
      tick(); tick(); tick(); tick();
      check_eq("t3_req_wait4", mem_request, 1);
      check_eq("t3_no_valid_wait4", data_valid, 0);
      tick();
      check_eq("t3_req_dropped", mem_request, 0);
      check_eq("t3_data_valid",  data_valid,  1);
      check_eq("t3_rdata_zero",  rdata,       0);
      check_eq("t3_rsp_error",   rsp_error,   1);
      check_eq("t3_bus_error",   bus_error,   1);
      data_request = 1'b0;
      tick();
      check_eq("t3_single_pulse", data_valid, 0);

      // Stray mem_valid in IDLE
      mem_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_valid = 1'b0;
      check_eq("sv_idle_no_ivalid", instr_valid, 0);
      check_eq("sv_idle_no_dvalid", data_valid,  0);
      check_eq("sv_idle_no_req",    mem_request, 0);
      check_eq("sv_idle_rdata",     rdata,       0);

      // Stray mem_valid in RESP
      instr_request = 1'b1; instr_address = 32'h200;
      tick();
      mem_valid = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_rdata = 32'hFFFFFFFF;
      check_eq("sv_resp_valid",  instr_valid, 1);
      check_eq("sv_resp_rdata",  rdata,       32'h12345678);
      check_eq("sv_resp_no_err", rsp_error,   0);
      instr_request = 1'b0;
      tick();
      mem_valid = 1'b0;
      check_eq("sv_after_no_valid", instr_valid, 0);
      check_eq("sv_after_no_req",   mem_request, 0);
      check_eq("sv_rdata_held",     rdata,       32'h12345678);
      check_eq("sv_bus_error_sticky", bus_error, 1);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("r_bus_error_clear", bus_error, 0);
      check_eq("r_rdata_clear",     rdata,     0);

      // Timeout boundary: mem_valid in the 4th WAIT cycle
      data_request = 1'b1; data_address = 32'h4000;
      tick(); tick(); tick(); tick();
      mem_valid = 1'b1; mem_rdata = 32'h0BADC0DE;
      tick();
      mem_valid = 1'b0;
      check_eq("b4_data_valid", data_valid, 1);
      check_eq("b4_rsp_error",  rsp_error,  0);
      check_eq("b4_rdata",      rdata,      32'h0BADC0DE);
      check_eq("b4_bus_error",  bus_error,  0);
      data_request = 1'b0;
      tick();

      // Reset in the middle of a WAIT_D
      data_request = 1'b1; data_we_re = WE_RE_WRITE; data_address = 32'h5000;
      data_wdata = 32'h55AA55AA; data_mask = 4'hC;
      tick(); tick();
      check_eq("m5_req_before_rst", mem_request, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("m5_rst_req",     mem_request, 0);
      check_eq("m5_rst_dvalid",  data_valid,  0);
      check_eq("m5_rst_addr",    mem_address, 0);
      check_eq("m5_rst_wdata",   mem_wdata,   0);
      check_eq("m5_rst_rdata",   rdata,       0);
      tick();
      check_eq("m5_reissue_req",   mem_request, 1);
      check_eq("m5_reissue_addr",  mem_address, 32'h5000);
      check_eq("m5_reissue_wdata", mem_wdata,   32'h55AA55AA);
      check_eq("m5_reissue_mask",  mem_mask,    4'hC);
      mem_valid = 1'b1; mem_rdata = 32'h0;
      tick();
      mem_valid = 1'b0;
      check_eq("m5_data_valid", data_valid, 1);
      data_request = 1'b0;
      tick();
      check_eq("m5_single_pulse", data_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
